// File: rtl/srd_byte_collector.sv
// ============================================================================
// Module      : srd_byte_collector
// Description : Collects SDRD bits sampled on qualified bus reads into frames
//               and holds each completed frame behind a valid/ack handshake.
//               Optional trailing odd-parity bit enabled by SRD_PARITY_EN.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module srd_byte_collector #(
  parameter int BITS      = 8,
  parameter int MSB_FIRST = 1,
  parameter int TIMEOUT   = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            bus_stb,
  input  logic            sser,
  input  logic            ba13,
  input  logic            ba12,
  input  logic            br_w,
  input  logic            sdrd,
  input  logic            sync_clr,
  output logic [BITS-1:0] byte_data,
  output logic            byte_valid,
  input  logic            byte_ack,
  output logic            overrun,
  output logic            parity_err,
  output logic            busy
);

`ifdef SRD_PARITY_EN
  localparam int c_PAR = 1;
`else
  localparam int c_PAR = 0;
`endif
  localparam int c_FL = BITS + c_PAR;
  localparam int c_CW = $clog2(c_FL + 1);
  localparam int c_IW = $clog2(TIMEOUT + 1);

  localparam logic [0:0] c_IDLE  = 1'b0;
  localparam logic [0:0] c_SHIFT = 1'b1;

  logic [0:0]      r_state;
  logic [0:0]      w_state_next;
  logic [c_FL-1:0] r_sr;
  logic [c_CW-1:0] r_cnt;
  logic [c_IW-1:0] r_idle;
  logic [BITS-1:0] r_data;
  logic            r_valid;
  logic            r_overrun;

  logic            w_qrd;
  logic            w_accept;
  logic            w_done;
  logic            w_tmo;
  logic [c_CW-1:0] w_pos;
  logic [c_CW-1:0] w_shamt;
  logic [c_CW-1:0] w_cnt_inc;
  logic [c_FL-1:0] w_frame;
  logic [BITS-1:0] w_data;

  assign w_qrd    = bus_stb & ~sser & ~ba13 & ba12 & br_w;
  assign w_accept = w_qrd & ~sync_clr;

  // Bits are placed by position into a cleared register, so the frame is
  // complete combinationally on the edge of the final qualified read.
  assign w_pos     = (r_state == c_IDLE) ? '0 : r_cnt;
  assign w_shamt   = (MSB_FIRST != 0) ? (c_CW'(c_FL - 1) - w_pos) : w_pos;
  assign w_frame   = r_sr | (c_FL'(sdrd) << w_shamt);
  assign w_cnt_inc = (r_state == c_IDLE) ? c_CW'(1) : (r_cnt + c_CW'(1));
  assign w_done    = w_accept & (w_cnt_inc == c_CW'(c_FL));
  assign w_tmo     = (r_state == c_SHIFT) & ~w_qrd & ~sync_clr &
                     (r_idle == c_IW'(TIMEOUT - 1));

  // With parity, the parity bit sits below the data (MSB-first) or above it.
  assign w_data = (MSB_FIRST != 0) ? w_frame[c_FL-1 -: BITS] : w_frame[BITS-1:0];

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_IDLE: begin
        if (w_accept) begin
          w_state_next = w_done ? c_IDLE : c_SHIFT;
        end
      end
      c_SHIFT: begin
        if (sync_clr) begin
          w_state_next = c_IDLE;
        end else if (w_qrd) begin
          w_state_next = w_done ? c_IDLE : c_SHIFT;
        end else if (w_tmo) begin
          w_state_next = c_IDLE;
        end
      end
      default: w_state_next = c_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy = (r_state == c_SHIFT);
  end

  // Frame assembly: shift register, bit counter and idle counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sr   <= '0;
      r_cnt  <= '0;
      r_idle <= '0;
    end else begin
      if (sync_clr || w_tmo || w_done) begin
        r_sr  <= '0;
        r_cnt <= '0;
      end else if (w_accept) begin
        r_sr  <= w_frame;
        r_cnt <= w_cnt_inc;
      end
      if ((w_state_next == c_SHIFT) && !w_qrd) begin
        r_idle <= r_idle + c_IW'(1);
      end else begin
        r_idle <= '0;
      end
    end
  end

  // Holding register and handshake; a completion coinciding with an ack wins
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (w_done && (!r_valid || byte_ack)) begin
        r_data  <= w_data;
        r_valid <= 1'b1;
      end else begin
        if (w_done) begin
          r_overrun <= 1'b1;
        end
        if (byte_ack) begin
          r_valid <= 1'b0;
        end
      end
    end
  end

`ifdef SRD_PARITY_EN
  logic r_perr;

  // Odd parity over data and parity bit; an even count of ones is an error.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_perr <= 1'b0;
    end else if (w_done && (!r_valid || byte_ack)) begin
      r_perr <= ~(^w_frame);
    end
  end

  assign parity_err = r_perr;
`else
  assign parity_err = 1'b0;
`endif

  assign byte_data  = r_data;
  assign byte_valid = r_valid;
  assign overrun    = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_srd_byte_collector.sv
// ============================================================================
// Module      : tb_srd_byte_collector
// Description : Directed self-checking bench for srd_byte_collector.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_srd_byte_collector;

`ifdef SRD_PARITY_EN
  localparam bit PAR_ON = 1'b1;
`else
  localparam bit PAR_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       bus_stb, sser, ba13, ba12, br_w, sdrd, sync_clr, byte_ack;
  logic [7:0] byte_data;
  logic       byte_valid, overrun, parity_err, busy;

  int checks   = 0;
  int failures = 0;

  srd_byte_collector #(.BITS(8), .MSB_FIRST(1), .TIMEOUT(255)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus_stb    (bus_stb),
    .sser       (sser),
    .ba13       (ba13),
    .ba12       (ba12),
    .br_w       (br_w),
    .sdrd       (sdrd),
    .sync_clr   (sync_clr),
    .byte_data  (byte_data),
    .byte_valid (byte_valid),
    .byte_ack   (byte_ack),
    .overrun    (overrun),
    .parity_err (parity_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Inputs change on the falling edge and are held across one rising edge;
  // the task returns on the next falling edge, where outputs are checked.
  task automatic step(input logic stb, input logic ss, input logic a13,
                      input logic a12, input logic rw, input logic sd,
                      input logic clr, input logic ack);
    bus_stb  = stb;
    sser     = ss;
    ba13     = a13;
    ba12     = a12;
    br_w     = rw;
    sdrd     = sd;
    sync_clr = clr;
    byte_ack = ack;
    @(negedge clk);
  endtask

  task automatic qbit(input logic b, input logic ack);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, b, 1'b0, ack);
  endtask

  task automatic nop();
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'bx, 1'b0, 1'b0);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic ack_last,
                           input logic flip);
    logic par;
    par = ~(^d) ^ flip;
    for (int i = 7; i >= 0; i--) begin
      qbit(d[i], (i == 0) ? (ack_last & ~PAR_ON) : 1'b0);
    end
    if (PAR_ON) qbit(par, ack_last);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    @(negedge clk);
    nop();
    nop();
    chk("reset_data", 32'(byte_data), 32'h00);
    chk("reset_valid", 32'(byte_valid), 32'd0);
    chk("reset_overrun", 32'(overrun), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_perr", 32'(parity_err), 32'd0);
    rst = 1'b0;
    nop();

    // A5 MSB first with non-qualified strobes interleaved
    qbit(1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    qbit(1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    qbit(1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    qbit(1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    qbit(1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    qbit(1'b1, 1'b0);
    qbit(1'b0, 1'b0);
    chk("mid_busy", 32'(busy), 32'd1);
    chk("mid_valid", 32'(byte_valid), 32'd0);
    qbit(1'b1, 1'b0);
    if (PAR_ON) qbit(1'b1, 1'b0);
    chk("a5_data", 32'(byte_data), 32'hA5);
    chk("a5_valid", 32'(byte_valid), 32'd1);
    chk("a5_busy", 32'(busy), 32'd0);
    chk("a5_perr", 32'(parity_err), 32'd0);

    // Overrun, then ack coincident with completion
    send_byte(8'h3C, 1'b0, 1'b0);
    chk("ovr_data", 32'(byte_data), 32'hA5);
    chk("ovr_flag", 32'(overrun), 32'd1);
    chk("ovr_valid", 32'(byte_valid), 32'd1);
    send_byte(8'h0F, 1'b1, 1'b0);
    chk("ackwin_data", 32'(byte_data), 32'h0F);
    chk("ackwin_valid", 32'(byte_valid), 32'd1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("ack_clears", 32'(byte_valid), 32'd0);
    chk("ack_keeps_data", 32'(byte_data), 32'h0F);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("ack_idle_ignored", 32'(byte_valid), 32'd0);

    // Idle timeout discards a partial frame after exactly 255 clocks
    qbit(1'b1, 1'b0);
    qbit(1'b0, 1'b0);
    qbit(1'b0, 1'b0);
    for (int i = 0; i < 254; i++) nop();
    chk("tmo_254_busy", 32'(busy), 32'd1);
    nop();
    chk("tmo_255_busy", 32'(busy), 32'd0);
    send_byte(8'h81, 1'b0, 1'b0);
    chk("tmo_next_data", 32'(byte_data), 32'h81);
    chk("tmo_next_valid", 32'(byte_valid), 32'd1);
    chk("ovr_sticky", 32'(overrun), 32'd1);

    // sync_clr beats a simultaneous qualified read
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) qbit(1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("clr_busy", 32'(busy), 32'd0);
    chk("clr_valid", 32'(byte_valid), 32'd0);
    send_byte(8'h5A, 1'b0, 1'b0);
    chk("clr_next_data", 32'(byte_data), 32'h5A);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("clr_keeps_valid", 32'(byte_valid), 32'd1);
    chk("clr_keeps_data", 32'(byte_data), 32'h5A);

    // Reset mid-frame loses everything
    qbit(1'b1, 1'b0);
    qbit(1'b1, 1'b0);
    qbit(1'b0, 1'b0);
    rst = 1'b1;
    nop();
    chk("rst_data", 32'(byte_data), 32'h00);
    chk("rst_valid", 32'(byte_valid), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    nop();

    if (PAR_ON) begin
      send_byte(8'hA5, 1'b0, 1'b0);
      chk("par_ok_perr", 32'(parity_err), 32'd0);
      send_byte(8'hA5, 1'b1, 1'b1);
      chk("par_bad_perr", 32'(parity_err), 32'd1);
      chk("par_bad_data", 32'(byte_data), 32'hA5);
    end else begin
      send_byte(8'hC3, 1'b0, 1'b0);
      chk("post_rst_data", 32'(byte_data), 32'hC3);
      chk("noparity_perr", 32'(parity_err), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
